// File: rtl/hazard_controller.sv
// Pipeline sequencer: operand forwarding, load-use detection, flush and
// multi-cycle sequencing, and the stall/flush/hold controls for fetch/decode/execute.
module hazard_controller #(
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned MC_TIMEOUT  = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       decode_rs1_addr_i,
  input  logic [4:0]       decode_rs2_addr_i,
  input  logic             decode_uses_rs1_i,
  input  logic             decode_uses_rs2_i,
  input  logic [4:0]       exec_rs1_addr_i,
  input  logic [4:0]       exec_rs2_addr_i,
  input  logic [4:0]       exec_rd_addr_i,
  input  logic             exec_mem_read_i,
  input  logic             exec_flush_i,
  input  logic             exec_mc_start_i,
  input  logic             exec_mc_done_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic             mem_reg_write_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             wb_reg_write_i,
  input  logic             mem_ready_i,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic             fetch_stall_o,
  output logic             decode_stall_o,
  output logic             decode_flush_o,
  output logic             exec_bubble_o,
  output logic             exec_hold_o,
  output logic             mc_error_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int unsigned MC_W = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FLUSH, MC_WAIT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic             mc_error_q, mc_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we, input logic [4:0] wb_rd);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'b01;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  assign load_use = exec_mem_read_i && (exec_rd_addr_i != 5'd0) &&
                    ((decode_uses_rs1_i && (decode_rs1_addr_i == exec_rd_addr_i)) ||
                     (decode_uses_rs2_i && (decode_rs2_addr_i == exec_rd_addr_i)));

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    mc_cnt_d       = mc_cnt_q;
    mc_error_d     = mc_error_q;
    fwd_rs1_sel_o  = 2'b00;
    fwd_rs2_sel_o  = 2'b00;
    fetch_stall_o  = 1'b0;
    decode_stall_o = 1'b0;
    decode_flush_o = 1'b0;
    exec_bubble_o  = 1'b0;
    exec_hold_o    = 1'b0;

    if (!rst_i) begin
      fwd_rs1_sel_o = fwd_sel(exec_rs1_addr_i, mem_reg_write_i, mem_rd_addr_i,
                              wb_reg_write_i, wb_rd_addr_i);
      fwd_rs2_sel_o = fwd_sel(exec_rs2_addr_i, mem_reg_write_i, mem_rd_addr_i,
                              wb_reg_write_i, wb_rd_addr_i);
      // Memory back-pressure overrides everything and freezes the sequencer.
      if (!mem_ready_i) begin
        fetch_stall_o  = 1'b1;
        decode_stall_o = 1'b1;
        exec_hold_o    = 1'b1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (exec_flush_i) begin
              decode_flush_o = 1'b1;
              exec_bubble_o  = 1'b1;
              if (FLUSH_EXTRA > 0) begin
                state_d     = FLUSH;
                flush_cnt_d = 3'(FLUSH_EXTRA);
              end
            end else if (exec_mc_start_i) begin
              fetch_stall_o  = 1'b1;
              decode_stall_o = 1'b1;
              exec_hold_o    = 1'b1;
              state_d        = MC_WAIT;
              mc_cnt_d       = '0;
            end else if (load_use) begin
              fetch_stall_o  = 1'b1;
              decode_stall_o = 1'b1;
              exec_bubble_o  = 1'b1;
            end
          end
          FLUSH: begin
            decode_flush_o = 1'b1;
            exec_bubble_o  = 1'b1;
            if (exec_flush_i) flush_cnt_d = 3'(FLUSH_EXTRA);
            else if (flush_cnt_q <= 3'd1) state_d = RUN;
            else flush_cnt_d = flush_cnt_q - 3'd1;
          end
          MC_WAIT: begin
            mc_cnt_d = mc_cnt_q + 1'b1;
            // The MC_TIMEOUT-th wait cycle is the abort cycle: stalls drop there.
            if (exec_mc_done_i) begin
              state_d = RUN;
            end else if (mc_cnt_q == MC_W'(MC_TIMEOUT - 1)) begin
              state_d    = RUN;
              mc_error_d = 1'b1;
            end else begin
              fetch_stall_o  = 1'b1;
              decode_stall_o = 1'b1;
              exec_hold_o    = 1'b1;
            end
          end
          default: state_d = RUN;
        endcase
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (fetch_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      mc_cnt_q    <= '0;
      mc_error_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mc_cnt_q    <= mc_cnt_d;
      mc_error_q  <= mc_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_error_o    = mc_error_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the five-stage core.
- Computes forwarding selects for the execute operands and detects load-use hazards.
- Sequences branch/jump flushes and multi-cycle execute operations, and generates stall, flush and hold controls for the fetch, decode and execute stages.
- Sits beside the execute stage; all pipeline-register enables and kills come from this block.

Parameters:
FLUSH_EXTRA, 1, cycles decode_flush_o stays high after the redirect cycle (covers fetch latency); legal range 0..7
MC_TIMEOUT, 64, maximum MC_WAIT cycles before abort; at least 2
CNT_W, 32, width of the stall performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
decode_rs1_addr_i  in  5  rs1 index of the instruction in decode
decode_rs2_addr_i  in  5  rs2 index of the instruction in decode
decode_uses_rs1_i  in  1  decode instruction reads rs1
decode_uses_rs2_i  in  1  decode instruction reads rs2
exec_rs1_addr_i  in  5  rs1 index of the instruction in execute
exec_rs2_addr_i  in  5  rs2 index of the instruction in execute
exec_rd_addr_i  in  5  rd of the instruction in execute
exec_mem_read_i  in  1  instruction in execute is a load
exec_flush_i  in  1  branch/jump taken in execute (redirect)
exec_mc_start_i  in  1  instruction in execute is a multi-cycle op
exec_mc_done_i  in  1  multi-cycle result valid
mem_rd_addr_i  in  5  rd in the memory stage
mem_reg_write_i  in  1  memory-stage instruction writes rd
wb_rd_addr_i  in  5  rd in writeback
wb_reg_write_i  in  1  writeback instruction writes rd
mem_ready_i  in  1  memory stage can accept
fwd_rs1_sel_o  out  2  00 = register file, 01 = memory-stage ALU result, 10 = writeback data
fwd_rs2_sel_o  out  2  same encoding for rs2
fetch_stall_o  out  1  hold PC and the fetch register
decode_stall_o  out  1  hold the decode register
decode_flush_o  out  1  replace the decode register with I_NOP/CONTROL_NOP
exec_bubble_o  out  1  load CONTROL_NOP into the execute input register
exec_hold_o  out  1  hold the execute input register contents
mc_error_o  out  1  sticky multi-cycle timeout flag
stall_count_o  out  CNT_W  saturating count of cycles with fetch_stall_o high

Behaviour:
- FSM states: RUN, FLUSH, MC_WAIT. Reset state is RUN.
- Reset values: every output is 0, the counters are cleared and mc_error_o is cleared. This applies to any reset, including a reset during FLUSH or MC_WAIT.
- Forwarding (combinational, all states):
  - MEM match: mem_reg_write_i and mem_rd_addr_i equals exec_rsX_addr_i and the address is not 0 → select 01.
  - Otherwise WB match (same rules using the wb_ ports) → select 10.
  - Otherwise → select 00.
  - x0 is never forwarded.
- Load-use hazard: exec_mem_read_i and exec_rd_addr_i is not 0, and the decode instruction uses rsX with decode_rsX_addr_i equal to exec_rd_addr_i.
- RUN state, evaluated in this priority order:
  1. exec_flush_i: decode_flush_o=1 and exec_bubble_o=1 in the same cycle. Go to FLUSH if FLUSH_EXTRA>0, otherwise stay in RUN. Load-use is ignored in this cycle.
  2. exec_mc_start_i: fetch_stall_o, decode_stall_o and exec_hold_o are 1. Go to MC_WAIT and clear the timeout counter.
  3. Load-use hazard: fetch_stall_o, decode_stall_o and exec_bubble_o are 1 for exactly one cycle. Stay in RUN; the condition clears once the load advances.
- FLUSH state:
  - decode_flush_o=1 and exec_bubble_o=1.
  - A down-counter loaded with FLUSH_EXTRA returns the FSM to RUN after FLUSH_EXTRA cycles.
  - A new exec_flush_i reloads the counter.
- MC_WAIT state:
  - fetch_stall_o, decode_stall_o and exec_hold_o are 1.
  - exec_flush_i is ignored.
  - On exec_mc_done_i: all three outputs drop in that cycle and the FSM returns to RUN.
  - If the counter reaches MC_TIMEOUT without done: set mc_error_o (sticky until reset), drop the stalls and return to RUN.
- mem_ready_i=0:
  - fetch_stall_o, decode_stall_o and exec_hold_o are forced to 1.
  - decode_flush_o and exec_bubble_o are forced to 0.
  - FSM state and all counters freeze. A flush request is held by execute and acted on once mem_ready_i returns.
- stall_count_o: increments each cycle fetch_stall_o=1 and saturates at all ones.

Test Plan:
1. Forwarding priority: mem rd=5 (we=1), wb rd=5 (we=1), exec rs1=5 → fwd_rs1_sel_o=01. Then mem we=0 → 10. Then rd=0 on both → 00.
2. Load-use: exec load rd=7, decode rs2=7 with uses_rs2=1 → fetch_stall_o, decode_stall_o and exec_bubble_o high for exactly one cycle. Next cycle, with mem rd=7, fwd_rs2_sel_o=01. stall_count_o=1.
3. Flush with FLUSH_EXTRA=1: exec_flush_i pulse in cycle N alongside a load-use hazard → decode_flush_o high in cycles N and N+1, no stall, state RUN at N+2.
4. Multi-cycle op: exec_mc_start_i, then exec_mc_done_i 10 cycles later → stalls high for 10 cycles and low in the done cycle. stall_count_o=10. mc_error_o=0.
5. Timeout: MC_TIMEOUT=8, done never asserted → mc_error_o rises after 8 MC_WAIT cycles, the FSM returns to RUN, and the flag stays set until rst_i.
6. mem_ready_i low for 3 cycles during FLUSH; reset asserted during MC_WAIT → FLUSH counter frozen, and after reset all outputs are 0 in state RUN.
